// File: rtl/hazard_scoreboard.sv
// Per-register stall scoreboard between Decode and Execute: stalls dependents of loads/multiplies.
// Optional macro STALL_CNT_EN builds a saturating 32-bit stall statistics counter.
module hazard_scoreboard #(
   parameter int AW       = 5,
   parameter int LOAD_LAT = 1,
   parameter int MUL_LAT  = 3,
   parameter int CW       = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [AW-1:0]       Rs1_D,
   input  logic [AW-1:0]       Rs2_D,
   input  logic                Rs1_used,
   input  logic                Rs2_used,
   input  logic [AW-1:0]       RD_D,
   input  logic                RegWriteD,
   input  logic                MemReadD,
   input  logic                MulD,
   input  logic                ValidD,
   input  logic                BranchFlush,
   output logic                PCWrite,
   output logic                IF_ID_Write,
   output logic                FlushE,
   output logic [(1<<AW)-1:0]  Busy,
   output logic [31:0]         stall_count
);

   localparam int NREG = 1 << AW;
   localparam logic [CW-1:0] LOAD_V = CW'(LOAD_LAT);
   localparam logic [CW-1:0] MUL_V  = CW'(MUL_LAT);
   localparam logic [CW-1:0] ZERO_V = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_V  = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0]   r_cnt [1:NREG-1];
   logic [NREG-1:0] w_busy;
   logic            w_haz;
   logic            w_stall;
   logic            w_issue;
   logic [CW-1:0]   w_new_cnt;

   // x0 has no counter and is never busy
   assign w_busy[0] = 1'b0;
   for (genvar g = 1; g < NREG; g++) begin : g_busy
      assign w_busy[g] = (r_cnt[g] != ZERO_V);
   end

   assign w_haz     = ValidD & ((Rs1_used & w_busy[Rs1_D]) | (Rs2_used & w_busy[Rs2_D]));
   assign w_stall   = w_haz & ~BranchFlush;
   assign w_issue   = ValidD & ~w_haz & ~BranchFlush;
   assign w_new_cnt = MemReadD ? LOAD_V : (MulD ? MUL_V : ZERO_V);

   assign PCWrite     = ~w_stall;
   assign IF_ID_Write = ~w_stall;
   assign FlushE      = w_haz | BranchFlush;
   assign Busy        = w_busy;

   // Newest producer reloads its counter; otherwise counters count down to zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 1; r < NREG; r++) r_cnt[r] <= ZERO_V;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (w_issue && RegWriteD && (RD_D == AW'(r))) r_cnt[r] <= w_new_cnt;
            else if (r_cnt[r] != ZERO_V)                  r_cnt[r] <= r_cnt[r] - ONE_V;
            else                                          r_cnt[r] <= r_cnt[r];
         end
      end
   end

`ifdef STALL_CNT_EN
   logic [31:0] r_stall_count;

   // Saturating count of stalled cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                    r_stall_count <= 32'h0;
      else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) r_stall_count <= r_stall_count + 32'h1;
      else                                         r_stall_count <= r_stall_count;
   end

   assign stall_count = r_stall_count;
`else
   assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters, LOAD_LAT=1, MUL_LAT=3).
module tb_hazard_scoreboard;

   logic        clk;
   logic        rst;
   logic [4:0]  Rs1_D, Rs2_D, RD_D;
   logic        Rs1_used, Rs2_used, RegWriteD, MemReadD, MulD, ValidD, BranchFlush;
   logic        PCWrite, IF_ID_Write, FlushE;
   logic [31:0] Busy;
   logic [31:0] stall_count;

   int n_cmp;
   int n_bad;
   int exp_stalls;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_used(Rs1_used), .Rs2_used(Rs2_used),
      .RD_D(RD_D), .RegWriteD(RegWriteD), .MemReadD(MemReadD), .MulD(MulD),
      .ValidD(ValidD), .BranchFlush(BranchFlush),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .FlushE(FlushE),
      .Busy(Busy), .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic mr, input logic mul, input logic bf);
      ValidD = v; Rs1_D = rs1; Rs1_used = u1; Rs2_D = rs2; Rs2_used = u2;
      RD_D = rd; RegWriteD = we; MemReadD = mr; MulD = mul; BranchFlush = bf;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_sc(input string tag);
`ifdef STALL_CNT_EN
      check(tag, stall_count, 32'(exp_stalls));
`else
      check(tag, stall_count, 32'h0);
`endif
   endtask

   task automatic check_ctl(input string tag, input logic stall, input logic flush, input logic [31:0] busy);
      check({tag, "_pcw"},  {31'h0, PCWrite},     {31'h0, ~stall});
      check({tag, "_ifid"}, {31'h0, IF_ID_Write}, {31'h0, ~stall});
      check({tag, "_flsh"}, {31'h0, FlushE},      {31'h0, flush});
      check({tag, "_busy"}, Busy, busy);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; exp_stalls = 0;
      rst = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #10;
      check_ctl("reset", 1'b0, 1'b0, 32'h0);
      check_sc("reset_sc");
      rst = 1'b1;
      step();

      // 1: lw x2,0(x0) then add x3,x2,x1
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      check_ctl("t1_lw", 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("t1_stall", 1'b1, 1'b1, 32'h0000_0004);
      step(); exp_stalls++;
      check_ctl("t1_issue", 1'b0, 1'b0, 32'h0);
      step();
      check_sc("t1_sc");

      // 2: mul x5 then reader of x5: three stall cycles
      drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check_ctl($sformatf("t2_stall%0d", i), 1'b1, 1'b1, 32'h0000_0020);
         step(); exp_stalls++;
      end
      check_ctl("t2_issue", 1'b0, 1'b0, 32'h0);
      check_sc("t2_sc");
      step();

      // 3: lw x0 + reader of x0; lw x4 + unused Rs2=4
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("t3_x0", 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ctl("t3_unused", 1'b0, 1'b0, 32'h0000_0010);
      step();

      // 4: branch flush with hazard pending; the flushed instruction must not issue
      drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
      check_ctl("t4_bf", 1'b0, 1'b1, 32'h0000_0020);
      step();
      drive(1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
      check_ctl("t4_dec", 1'b0, 1'b0, 32'h0000_0020);
      step();
      check_ctl("t4_novalid", 1'b0, 1'b0, 32'h0000_0020);
      step();
      check_ctl("t4_drained", 1'b0, 1'b0, 32'h0);

      // 5: WAW, addi x6 right after mul x6 clears the counter
      drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("t5_addi", 1'b0, 1'b0, 32'h0000_0040);
      step();
      drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("t5_reader", 1'b0, 1'b0, 32'h0);
      step();
      check_sc("t5_sc");

      // 6: asynchronous reset in the middle of a multiply stall
      drive(1'b1, 5'd1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("t6_stall", 1'b1, 1'b1, 32'h0000_0020);
      step(); exp_stalls++;
      #2;
      rst = 1'b0;
      exp_stalls = 0;
      #1;
      check_ctl("t6_async", 1'b0, 1'b0, 32'h0);
      check_sc("t6_sc_clr");
      #4;
      rst = 1'b1;
      #1;
      check_ctl("t6_after", 1'b0, 1'b0, 32'h0);
      step();
      check_ctl("t6_issued", 1'b0, 1'b0, 32'h0);
      check_sc("t6_sc");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
